// File: rtl/afe_atten_spi.sv
// Shift-out controller for the two LBL208 AFE step attenuators: one CSR strobe -> MSB-first word, latch pulse, shadow readback.
// Optional build macro AFE_SPI_BROADCAST_EN makes select 3 drive both channels at once.
module afe_atten_spi #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic        sysClk,
    input  logic        sysReset_n,
    input  logic        csrStrobe,
    input  logic [31:0] gpioOut,
    output logic [31:0] status,
    output logic [1:0]  AFE_SPI_CLK,
    output logic [1:0]  AFE_SPI_SDI,
    output logic [1:0]  AFE_SPI_LE
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [BW-1:0]         r_bit;
    logic [BW-1:0]         w_bit_next;
    logic [1:0]            r_mask;
    logic                  r_overrun;
    logic                  r_bad_select;
    logic [1:0]            r_pin_clk;
    logic [1:0]            r_pin_sdi;
    logic [1:0]            r_pin_le;
    logic [1:0]            w_clk_next;
    logic [1:0]            w_sdi_next;
    logic [1:0]            w_le_next;
    logic [1:0]            w_sel_mask;
    logic                  w_sel_valid;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_cnt_done;
    logic                  w_gap_exit;
    logic [DATA_WIDTH-1:0] r_shadow [2];
    logic                  w_unused;

    assign w_unused = ^{gpioOut[31:26], gpioOut[23:DATA_WIDTH]};

    // Channel select decode: a zero mask means the select is invalid.
    always_comb begin
        w_sel_mask = 2'b00;
        case (gpioOut[25:24])
            2'd0:    w_sel_mask = 2'b01;
            2'd1:    w_sel_mask = 2'b10;
`ifdef AFE_SPI_BROADCAST_EN
            2'd3:    w_sel_mask = 2'b11;
`else
            2'd3:    w_sel_mask = 2'b00;
`endif
            default: w_sel_mask = 2'b00;
        endcase
    end

    assign w_sel_valid = |w_sel_mask;
    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = csrStrobe && w_idle && w_sel_valid;
    assign w_cnt_done  = (r_cnt == '0);
    assign w_gap_exit  = (r_state == S_GAP) && w_cnt_done;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_SHIFT_LO;
                w_shift_next = r_word;
                w_bit_next   = BW'(DATA_WIDTH - 1);
            end
            S_SHIFT_LO: begin
                if (w_cnt_done) w_state_next = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (w_cnt_done) begin
                    if (r_bit == '0) begin
                        w_state_next = S_LATCH;
                    end else begin
                        w_state_next = S_SHIFT_LO;
                        w_shift_next = r_shift << 1;
                        w_bit_next   = r_bit - 1'b1;
                    end
                end
            end
            S_LATCH: begin
                if (w_cnt_done) w_state_next = S_GAP;
            end
            S_GAP: begin
                if (w_cnt_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // One half-period down-counter, reloaded on every state change.
        if (w_state_next != r_state) begin
            w_cnt_next = CW'(CLK_DIV - 1);
        end else if (!w_cnt_done) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    // Pins are registered from the next state so they change exactly with the state and never glitch.
    always_comb begin
        w_clk_next = (w_state_next == S_SHIFT_HI) ? r_mask : 2'b00;
        w_le_next  = (w_state_next == S_LATCH)    ? r_mask : 2'b00;
        w_sdi_next = 2'b00;
        if ((w_state_next == S_SHIFT_LO) && (r_state != S_SHIFT_LO)) begin
            w_sdi_next = w_shift_next[DATA_WIDTH-1] ? r_mask : 2'b00;
        end else if ((w_state_next == S_SHIFT_LO) || (w_state_next == S_SHIFT_HI) ||
                     (w_state_next == S_LATCH)) begin
            w_sdi_next = r_pin_sdi;
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_word       <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_mask       <= '0;
            r_overrun    <= 1'b0;
            r_bad_select <= 1'b0;
            r_pin_clk    <= '0;
            r_pin_sdi    <= '0;
            r_pin_le     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_bit     <= w_bit_next;
            r_pin_clk <= w_clk_next;
            r_pin_sdi <= w_sdi_next;
            r_pin_le  <= w_le_next;
            if (w_accept) begin
                r_word       <= gpioOut[DATA_WIDTH-1:0];
                r_mask       <= w_sel_mask;
                r_overrun    <= 1'b0;
                r_bad_select <= 1'b0;
            end else if (csrStrobe) begin
                if (!w_idle) r_overrun    <= 1'b1;
                else         r_bad_select <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_shadow
            always_ff @(posedge sysClk or negedge sysReset_n) begin
                if (!sysReset_n) begin
                    r_shadow[gi] <= '0;
                end else if (w_gap_exit && r_mask[gi]) begin
                    r_shadow[gi] <= r_word;
                end
            end
        end
    endgenerate

    always_comb begin
        status        = '0;
        status[31]    = !w_idle;
        status[30]    = r_overrun;
        status[29]    = r_bad_select;
        status[15:8]  = 8'(r_shadow[1]);
        status[7:0]   = 8'(r_shadow[0]);
    end

    assign AFE_SPI_CLK = r_pin_clk;
    assign AFE_SPI_SDI = r_pin_sdi;
    assign AFE_SPI_LE  = r_pin_le;

endmodule

// File: tb/tb_afe_atten_spi.sv
// Bench for afe_atten_spi: per-cycle pin/busy checks against a timeline model derived from word, select and CLK_DIV.
module tb_afe_atten_spi;

    localparam int CD       = 4;
    localparam int DW       = 8;
    localparam int BUSY_LEN = 1 + (2 * DW + 2) * CD;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        strobe = 1'b0;
    logic [31:0] gpio   = '0;
    logic [31:0] status;
    logic [1:0]  spi_clk;
    logic [1:0]  spi_sdi;
    logic [1:0]  spi_le;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_shadow [2];
    bit         m_ovr;
    bit         m_bad;

    always #5 clk = ~clk;

    afe_atten_spi #(.CLK_DIV(CD), .DATA_WIDTH(DW)) dut (
        .sysClk      (clk),
        .sysReset_n  (rst_n),
        .csrStrobe   (strobe),
        .gpioOut     (gpio),
        .status      (status),
        .AFE_SPI_CLK (spi_clk),
        .AFE_SPI_SDI (spi_sdi),
        .AFE_SPI_LE  (spi_le)
    );

    function automatic logic [1:0] sel_mask(input logic [1:0] sel);
        case (sel)
            2'd0: return 2'b01;
            2'd1: return 2'b10;
`ifdef AFE_SPI_BROADCAST_EN
            2'd3: return 2'b11;
`endif
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] exp_status(input bit busy);
        logic [31:0] s;
        s        = '0;
        s[31]    = busy;
        s[30]    = m_ovr;
        s[29]    = m_bad;
        s[15:8]  = m_shadow[1];
        s[7:0]   = m_shadow[0];
        return s;
    endfunction

    // Expected {CLK, SDI, LE} at cycle t after acceptance (t=0 is the load cycle).
    function automatic logic [5:0] exp_pins(input int t, input logic [7:0] w, input logic [1:0] m);
        int         sh_end;
        int         k;
        logic [1:0] c;
        logic [1:0] s;
        logic [1:0] l;
        c      = '0;
        s      = '0;
        l      = '0;
        sh_end = 1 + 2 * DW * CD;
        if (t >= 1 && t < sh_end) begin
            k = (t - 1) / (2 * CD);
            if (((t - 1) % (2 * CD)) >= CD) c = m;
            if (w[DW - 1 - k]) s = m;
        end else if (t >= sh_end && t < sh_end + CD) begin
            l = m;
            if (w[0]) s = m;
        end
        return {c, s, l};
    endfunction

    task automatic check_waveform(input logic [7:0] w, input logic [1:0] m, input int intrude_at,
                                  input logic [31:0] intr_data, input int stop_at,
                                  input bit chain, input logic [31:0] chain_data);
        logic [5:0] e;
        logic [5:0] got;
        for (int t = 0; t <= BUSY_LEN; t++) begin
            @(negedge clk);
            strobe = 1'b0;
            got = {spi_clk, spi_sdi, spi_le};
            e   = exp_pins(t, w, m);
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL pins t=%0d got clk/sdi/le=%b expected=%b", t, got, e);
            end
            n_vec++;
            if (status[31] !== (t < BUSY_LEN)) begin
                n_err++;
                $display("FAIL busy t=%0d got=%b expected=%b", t, status[31], (t < BUSY_LEN));
            end
            if (t == BUSY_LEN) begin
                for (int c = 0; c < 2; c++) if (m[c]) m_shadow[c] = w;
            end
            if (t == 0 || t == BUSY_LEN) begin
                n_vec++;
                if (status !== exp_status(t < BUSY_LEN)) begin
                    n_err++;
                    $display("FAIL status t=%0d got=%08h expected=%08h", t, status, exp_status(t < BUSY_LEN));
                end
            end
            if (t == intrude_at) begin
                strobe = 1'b1;
                gpio   = intr_data;
                m_ovr  = 1'b1;
            end
            if (t == stop_at) return;
            if (t == BUSY_LEN && chain) begin
                strobe = 1'b1;
                gpio   = chain_data;
            end
        end
    endtask

    task automatic check_idle(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            strobe = 1'b0;
            n_vec++;
            if ({spi_clk, spi_sdi, spi_le, status[31]} !== 7'b0) begin
                n_err++;
                $display("FAIL idle t=%0d got pins=%b busy=%b expected all 0", t,
                         {spi_clk, spi_sdi, spi_le}, status[31]);
            end
        end
        n_vec++;
        if (status !== exp_status(1'b0)) begin
            n_err++;
            $display("FAIL idle_status got=%08h expected=%08h", status, exp_status(1'b0));
        end
    endtask

    task automatic do_txn(input logic [31:0] data, input int intrude_at);
        logic [1:0]  m;
        logic [31:0] intr;
        m    = sel_mask(data[25:24]);
        intr = $urandom;
        @(negedge clk);
        strobe = 1'b1;
        gpio   = data;
        if (m != 2'b00) begin
            m_ovr = 1'b0;
            m_bad = 1'b0;
            check_waveform(data[7:0], m, intrude_at, intr, -1, 1'b0, 32'h0);
        end else begin
            m_bad = 1'b1;
            check_idle(8);
        end
        $display("txn data=%08h mask=%b intrude=%0d status=%08h", data, m, intrude_at, status);
    endtask

    task automatic model_reset();
        m_shadow[0] = '0;
        m_shadow[1] = '0;
        m_ovr       = 1'b0;
        m_bad       = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({spi_clk, spi_sdi, spi_le} !== 6'b0 || status !== 32'h0) begin
            n_err++;
            $display("FAIL reset got pins=%b status=%08h expected 0", {spi_clk, spi_sdi, spi_le}, status);
        end
        rst_n = 1'b1;
        check_idle(4);
        $display("txn reset status=%08h", status);
    endtask

    task automatic test_single();
        do_txn(32'h0000_00A5, -1);
        do_txn(32'h0100_003C, -1);
    endtask

    task automatic test_overrun();
        do_txn(32'h0000_00C3, 20);
        do_txn(32'h0100_0011, -1);
    endtask

    task automatic test_bad_select();
        do_txn(32'h0200_00FF, -1);
    endtask

    task automatic test_broadcast();
        do_txn(32'h0300_005A, -1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        strobe = 1'b1;
        gpio   = 32'h0000_0096;
        m_ovr  = 1'b0;
        m_bad  = 1'b0;
        check_waveform(8'h96, 2'b01, -1, 32'h0, -1, 1'b1, 32'h0100_0069);
        m_ovr = 1'b0;
        m_bad = 1'b0;
        check_waveform(8'h69, 2'b10, -1, 32'h0, -1, 1'b0, 32'h0);
        $display("txn back_to_back status=%08h", status);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        strobe = 1'b1;
        gpio   = 32'h0100_00E7;
        m_ovr  = 1'b0;
        m_bad  = 1'b0;
        check_waveform(8'hE7, 2'b10, -1, 32'h0, 30, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({spi_clk, spi_sdi, spi_le} !== 6'b0 || status !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid got pins=%b status=%08h expected 0", {spi_clk, spi_sdi, spi_le}, status);
        end
        $display("txn reset_mid status=%08h", status);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(32'h0000_0042, -1);
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          intr;
        for (int i = 0; i < 16; i++) begin
            d    = $urandom;
            intr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BUSY_LEN - 1)) : -1;
            do_txn(d, intr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_bad_select();
        test_broadcast();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
